// File: rtl/fibonacci_pkg.sv
// Shared types and constants for the Fibonacci sequence generator.
// Holds the FSM state encoding, the sequence seeds and a max-index helper.
package fibonacci_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_CALC   = 2'd2
   } fib_state_e;

   localparam int unsigned SEED_A = 32'd0;
   localparam int unsigned SEED_B = 32'd1;

   // Largest index whose Fibonacci term still fits in 'width' unsigned bits.
   function automatic int max_fib_idx(input int width);
      longint unsigned fa;
      longint unsigned fb;
      longint unsigned ft;
      longint unsigned lim;
      int              res;
      fa  = 64'd0;
      fb  = 64'd1;
      lim = 64'd1 << width;
      res = 0;
      for (int k = 0; k < 96; k++) begin
         if (fb < lim) begin
            ft  = fa + fb;
            fa  = fb;
            fb  = ft;
            res = res + 32'sd1;
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/fibonacci_seq_gen_core.sv
// Term datapath: a = F(idx), b = F(idx+1) with one extra bit marking overflow.
// Controlled by clear and advance strobes; holds when neither is asserted.
module fibonacci_core
   import fibonacci_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             adv,
   output logic [WIDTH-1:0] a,
   output logic [IDX_W-1:0] idx,
   output logic             ovf_pend
);

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH:0]   b_q, b_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   // Next-term computation; the sum keeps its carry so overflow is never lost.
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      idx_d = idx_q;
      if (clr) begin
         a_d   = WIDTH'(SEED_A);
         b_d   = (WIDTH+1)'(SEED_B);
         idx_d = IDX_W'(0);
      end else if (adv) begin
         a_d   = b_q[WIDTH-1:0];
         b_d   = {1'b0, a_q} + {1'b0, b_q[WIDTH-1:0]};
         idx_d = idx_q + IDX_W'(1);
      end else begin
         a_d   = a_q;
      end
   end

   // Term registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= WIDTH'(SEED_A);
         b_q   <= (WIDTH+1)'(SEED_B);
         idx_q <= IDX_W'(0);
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         idx_q <= idx_d;
      end
   end

   assign a        = a_q;
   assign idx      = idx_q;
   assign ovf_pend = b_q[WIDTH];

endmodule

// File: rtl/fibonacci_seq_gen.sv
// Fibonacci generator top: stream / Nth-term FSM with start-busy-done handshake,
// sticky overflow flag and wrap-or-saturate policy around the term datapath.
module fibonacci_seq_gen
   import fibonacci_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int IDX_W = 6,
   parameter bit WRAP  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enb,
   input  logic             mode,
   input  logic             start,
   input  logic [IDX_W-1:0] n,
   output logic [WIDTH-1:0] fibout,
   output logic [IDX_W-1:0] idx,
   output logic             valid,
   output logic             busy,
   output logic             done,
   output logic             ovf
);

   fib_state_e       state_q, state_d;
   logic [IDX_W-1:0] n_lat_q, n_lat_d;
   logic             ovf_q, ovf_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             core_clr_s, core_adv_s, ovf_pend_s;

   fibonacci_core #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_core (
      .clk      (clk),
      .rst      (rst),
      .clr      (core_clr_s),
      .adv      (core_adv_s),
      .a        (fibout),
      .idx      (idx),
      .ovf_pend (ovf_pend_s)
   );

   // Next-state and control; a taken start always wins over an overflow event.
   always_comb begin
      state_d    = state_q;
      n_lat_d    = n_lat_q;
      ovf_d      = ovf_q;
      valid_d    = 1'b0;
      done_d     = 1'b0;
      core_clr_s = 1'b0;
      core_adv_s = 1'b0;
      case (state_q)
         ST_IDLE, ST_STREAM: begin
            if (start && mode) begin
               n_lat_d    = n;
               core_clr_s = 1'b1;
               ovf_d      = 1'b0;
               state_d    = ST_CALC;
            end else if (!mode && (start || (enb && state_q == ST_IDLE))) begin
               core_clr_s = 1'b1;
               ovf_d      = 1'b0;
               valid_d    = 1'b1;
               state_d    = ST_STREAM;
            end else if (enb && state_q == ST_STREAM) begin
               if (ovf_pend_s) begin
                  ovf_d = 1'b1;
                  if (WRAP) begin
                     core_clr_s = 1'b1;
                     valid_d    = 1'b1;
                  end else begin
                     valid_d    = 1'b0;
                  end
               end else begin
                  core_adv_s = 1'b1;
                  valid_d    = 1'b1;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_CALC: begin
            if (enb) begin
               if (idx == n_lat_q) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else if (ovf_pend_s) begin
                  ovf_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  core_adv_s = 1'b1;
               end
            end else begin
               state_d = ST_CALC;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_CALC);
   end

   // Control and handshake registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         n_lat_q <= IDX_W'(0);
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         n_lat_q <= n_lat_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign valid = valid_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_fibonacci_seq_gen.sv
// Self-checking bench: a WRAP=1 and a WRAP=0 instance share inputs; directed
// scenarios plus randomized traffic checked against an index-level model.
module tb_fibonacci_seq_gen;
   import fibonacci_pkg::*;

   localparam int W    = 12;
   localparam int IW   = 6;
   localparam int MAXI = max_fib_idx(W);

   typedef logic [W+IW+3:0] obs_t;

   logic          clk = 1'b0;
   logic          rst, enb, mode, start;
   logic [IW-1:0] n;
   logic [W-1:0]  fib_w, fib_s;
   logic [IW-1:0] idx_w, idx_s;
   logic          valid_w, busy_w, done_w, ovf_w;
   logic          valid_s, busy_s, done_s, ovf_s;

   int total = 0;
   int bad   = 0;

   int m_st[2];
   int m_idx[2];
   int m_n[2];
   bit m_ovf[2];
   bit m_valid[2];
   bit m_done[2];

   always #5 clk = ~clk;

   fibonacci_seq_gen #(.WIDTH(W), .IDX_W(IW), .WRAP(1'b1)) dut_wrap (
      .clk(clk), .rst(rst), .enb(enb), .mode(mode), .start(start), .n(n),
      .fibout(fib_w), .idx(idx_w), .valid(valid_w), .busy(busy_w), .done(done_w), .ovf(ovf_w)
   );

   fibonacci_seq_gen #(.WIDTH(W), .IDX_W(IW), .WRAP(1'b0)) dut_sat (
      .clk(clk), .rst(rst), .enb(enb), .mode(mode), .start(start), .n(n),
      .fibout(fib_s), .idx(idx_s), .valid(valid_s), .busy(busy_s), .done(done_s), .ovf(ovf_s)
   );

   function automatic int fibf(input int k);
      int fa = 0;
      int fb = 1;
      int ft;
      for (int i = 0; i < k; i++) begin
         ft = fa + fb;
         fa = fb;
         fb = ft;
      end
      return fa;
   endfunction

   function automatic obs_t obs_w();
      return {fib_w, idx_w, valid_w, busy_w, done_w, ovf_w};
   endfunction

   function automatic obs_t obs_s();
      return {fib_s, idx_s, valid_s, busy_s, done_s, ovf_s};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_calc(input int nn);
      mode  = 1'b1;
      n     = IW'(nn);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int cnt);
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (done_w !== 1'b1 && cnt < 100);
   endtask

   task automatic test_reset();
      rst = 1'b1; enb = 1'b0; mode = 1'b0; start = 1'b0; n = '0;
      #12;
      total++;
      if (obs_w() !== obs_t'(0) || obs_s() !== obs_t'(0)) begin
         bad++;
         $display("FAIL reset got wrap=%h sat=%h want 0", obs_w(), obs_s());
      end
      #3 rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_stream_basic();
      mode = 1'b0; enb = 1'b1; start = 1'b0;
      tick();
      for (int k = 0; k <= 8; k++) begin
         total++;
         if (fib_w !== W'(fibf(k)) || idx_w !== IW'(k) || valid_w !== 1'b1 || ovf_w !== 1'b0 ||
             obs_s() !== obs_w()) begin
            bad++;
            $display("FAIL stream_basic k=%0d got fib=%0d idx=%0d valid=%b ovf=%b want fib=%0d idx=%0d valid=1 ovf=0",
                     k, fib_w, idx_w, valid_w, ovf_w, fibf(k), k);
         end
         tick();
      end
   endtask

   task automatic test_stream_overflow();
      int guard = 0;
      while (idx_w !== IW'(MAXI) && guard < 60) begin
         tick();
         guard++;
      end
      total++;
      if (fib_w !== W'(fibf(MAXI)) || idx_w !== IW'(MAXI) || fib_s !== W'(fibf(MAXI))) begin
         bad++;
         $display("FAIL stream_last got fib=%0d idx=%0d want fib=%0d idx=%0d", fib_w, idx_w, fibf(MAXI), MAXI);
      end
      tick();
      total++;
      if (fib_w !== W'(0) || idx_w !== IW'(0) || ovf_w !== 1'b1 || valid_w !== 1'b1) begin
         bad++;
         $display("FAIL stream_wrap got fib=%0d idx=%0d ovf=%b valid=%b want 0 0 1 1", fib_w, idx_w, ovf_w, valid_w);
      end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (fib_s !== W'(fibf(MAXI)) || idx_s !== IW'(MAXI) || valid_s !== 1'b0 || ovf_s !== 1'b1) begin
            bad++;
            $display("FAIL stream_sat k=%0d got fib=%0d idx=%0d valid=%b ovf=%b want %0d %0d 0 1",
                     k, fib_s, idx_s, valid_s, ovf_s, fibf(MAXI), MAXI);
         end
         if (k < 3) begin
            tick();
            total++;
            if (fib_w !== W'(fibf(k + 1)) || idx_w !== IW'(k + 1) || ovf_w !== 1'b1 || valid_w !== 1'b1) begin
               bad++;
               $display("FAIL stream_after_wrap k=%0d got fib=%0d idx=%0d ovf=%b want fib=%0d idx=%0d ovf=1",
                        k + 1, fib_w, idx_w, ovf_w, fibf(k + 1), k + 1);
            end
         end
      end
   endtask

   task automatic test_stream_stall();
      enb = 1'b0;
      repeat (2) tick();
      total++;
      if (fib_w !== W'(2) || idx_w !== IW'(3) || valid_w !== 1'b0) begin
         bad++;
         $display("FAIL stream_stall got fib=%0d idx=%0d valid=%b want 2 3 0", fib_w, idx_w, valid_w);
      end
      enb = 1'b1;
      tick();
      total++;
      if (fib_w !== W'(3) || idx_w !== IW'(4) || valid_w !== 1'b1) begin
         bad++;
         $display("FAIL stream_resume got fib=%0d idx=%0d valid=%b want 3 4 1", fib_w, idx_w, valid_w);
      end
   endtask

   task automatic test_nth();
      int cnt;
      start_calc(10);
      total++;
      if (busy_w !== 1'b1 || ovf_w !== 1'b0 || ovf_s !== 1'b0 || valid_w !== 1'b0) begin
         bad++;
         $display("FAIL nth_start got busy=%b ovf=%b/%b valid=%b want 1 0/0 0", busy_w, ovf_w, ovf_s, valid_w);
      end
      wait_done(cnt);
      total++;
      if (cnt != 11 || fib_w !== W'(55) || idx_w !== IW'(10) || ovf_w !== 1'b0 || busy_w !== 1'b0 ||
          obs_s() !== obs_w()) begin
         bad++;
         $display("FAIL nth10 got lat=%0d fib=%0d idx=%0d ovf=%b busy=%b want 11 55 10 0 0",
                  cnt, fib_w, idx_w, ovf_w, busy_w);
      end
      tick();
      total++;
      if (done_w !== 1'b0 || busy_w !== 1'b0 || fib_w !== W'(55)) begin
         bad++;
         $display("FAIL done_pulse got done=%b busy=%b fib=%0d want 0 0 55", done_w, busy_w, fib_w);
      end
      start_calc(0);
      wait_done(cnt);
      total++;
      if (cnt != 1 || fib_w !== W'(0) || idx_w !== IW'(0)) begin
         bad++;
         $display("FAIL nth0 got lat=%0d fib=%0d idx=%0d want 1 0 0", cnt, fib_w, idx_w);
      end
   endtask

   task automatic test_nth_overflow();
      int cnt;
      start_calc(25);
      wait_done(cnt);
      total++;
      if (cnt != MAXI + 1 || fib_w !== W'(fibf(MAXI)) || idx_w !== IW'(MAXI) || ovf_w !== 1'b1 ||
          obs_s() !== obs_w()) begin
         bad++;
         $display("FAIL nth_ovf got lat=%0d fib=%0d idx=%0d ovf=%b want %0d %0d %0d 1",
                  cnt, fib_w, idx_w, ovf_w, MAXI + 1, fibf(MAXI), MAXI);
      end
      start_calc(5);
      total++;
      if (ovf_w !== 1'b0) begin
         bad++;
         $display("FAIL ovf_clear got ovf=%b want 0", ovf_w);
      end
      wait_done(cnt);
      total++;
      if (cnt != 6 || fib_w !== W'(5) || idx_w !== IW'(5)) begin
         bad++;
         $display("FAIL nth5 got lat=%0d fib=%0d idx=%0d want 6 5 5", cnt, fib_w, idx_w);
      end
   endtask

   task automatic test_back_to_back_stall();
      int cnt;
      int c2;
      start_calc(10);
      cnt = 0;
      repeat (3) begin tick(); cnt++; end
      enb = 1'b0;
      repeat (3) begin tick(); cnt++; end
      total++;
      if (idx_w !== IW'(3) || busy_w !== 1'b1 || done_w !== 1'b0) begin
         bad++;
         $display("FAIL calc_stall got idx=%0d busy=%b done=%b want 3 1 0", idx_w, busy_w, done_w);
      end
      enb = 1'b1;
      wait_done(c2);
      cnt += c2;
      total++;
      if (cnt != 14 || fib_w !== W'(55)) begin
         bad++;
         $display("FAIL stall_lat got lat=%0d fib=%0d want 14 55", cnt, fib_w);
      end
   endtask

   task automatic test_reset_mid_calc();
      bit seen = 1'b0;
      start_calc(10);
      repeat (4) tick();
      rst = 1'b1;
      #1;
      total++;
      if (obs_w() !== obs_t'(0) || obs_s() !== obs_t'(0)) begin
         bad++;
         $display("FAIL rst_mid got wrap=%h sat=%h want 0", obs_w(), obs_s());
      end
      repeat (2) begin tick(); seen = seen | done_w; end
      rst = 1'b0;
      repeat (15) begin tick(); seen = seen | done_w | busy_w; end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL rst_abort got done_or_busy=%b want 0", seen);
      end
   endtask

   task automatic model_restart(input int k);
      if (start && mode) begin
         m_n[k] = int'(n); m_idx[k] = 0; m_ovf[k] = 1'b0; m_st[k] = 2;
      end else begin
         m_idx[k] = 0; m_ovf[k] = 1'b0; m_st[k] = 1; m_valid[k] = 1'b1;
      end
   endtask

   task automatic model_step(input int k, input bit wrap);
      m_valid[k] = 1'b0;
      m_done[k]  = 1'b0;
      if (m_st[k] == 0) begin
         if ((start && mode) || (!mode && (start || enb))) model_restart(k);
      end else if (m_st[k] == 1) begin
         if (start) begin
            model_restart(k);
         end else if (enb) begin
            if (m_idx[k] == MAXI) begin
               m_ovf[k] = 1'b1;
               if (wrap) begin m_idx[k] = 0; m_valid[k] = 1'b1; end
            end else begin
               m_idx[k]++;
               m_valid[k] = 1'b1;
            end
         end
      end else if (enb) begin
         if (m_idx[k] == m_n[k]) begin
            m_done[k] = 1'b1; m_st[k] = 0;
         end else if (m_idx[k] == MAXI) begin
            m_ovf[k] = 1'b1; m_done[k] = 1'b1; m_st[k] = 0;
         end else begin
            m_idx[k]++;
         end
      end
   endtask

   task automatic test_random();
      obs_t exp;
      obs_t got;
      rst = 1'b1; start = 1'b0; enb = 1'b0;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_st[k] = 0; m_idx[k] = 0; m_n[k] = 0;
         m_ovf[k] = 1'b0; m_valid[k] = 1'b0; m_done[k] = 1'b0;
      end
      for (int c = 0; c < 2000; c++) begin
         enb   = ($urandom_range(0, 7) != 0);
         mode  = 1'($urandom_range(0, 1));
         start = ($urandom_range(0, 23) == 0);
         n     = ($urandom_range(0, 3) == 0) ? IW'($urandom_range(0, 63)) : IW'($urandom_range(0, 20));
         model_step(0, 1'b1);
         model_step(1, 1'b0);
         tick();
         for (int k = 0; k < 2; k++) begin
            exp = {W'(fibf(m_idx[k])), IW'(m_idx[k]), m_valid[k], (m_st[k] == 2), m_done[k], m_ovf[k]};
            got = (k == 0) ? obs_w() : obs_s();
            total++;
            if (got !== exp) begin
               bad++;
               $display("FAIL random cyc=%0d inst=%0d got=%h want=%h", c, k, got, exp);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream_basic();
      test_stream_overflow();
      test_stream_stall();
      test_nth();
      test_nth_overflow();
      test_back_to_back_stall();
      test_reset_mid_calc();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
